// File: rtl/lcd_drv_gen_if.sv
// Ready/valid request channel between the command sequencer and the LCD driver.
interface lcd_drv_gen_if;
  logic [9:0] data_i;
  logic       data_valid_i;
  logic       device_ready_o;

  modport master (
    output data_i,
    output data_valid_i,
    input  device_ready_o
  );

  modport slave (
    input  data_i,
    input  data_valid_i,
    output device_ready_o
  );
endinterface

// File: rtl/lcd_drv_gen.sv
// HD44780-class character-LCD driver: one byte (or a lone high nibble) per
// accepted transaction, sequenced onto RS/EN/DB with programmable timing.
module lcd_drv_gen #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned T_SETUP   = 5,
  parameter int unsigned T_EN      = 50,
  parameter int unsigned T_NIB     = 100,
  parameter int unsigned T_SHORT   = 4000,
  parameter int unsigned T_LONG    = 164000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  lcd_drv_gen_if.slave         bus,
  output logic                 rs_o,
  output logic                 rw_o,
  output logic                 en_o,
  output logic [BUS_WIDTH-1:0] lcd_data_o
);

  localparam int unsigned T_MAX0 = (T_SETUP > T_EN)    ? T_SETUP : T_EN;
  localparam int unsigned T_MAX1 = (T_MAX0 > T_NIB)    ? T_MAX0  : T_NIB;
  localparam int unsigned T_MAX2 = (T_MAX1 > T_SHORT)  ? T_MAX1  : T_SHORT;
  localparam int unsigned T_MAX  = (T_MAX2 > T_LONG)   ? T_MAX2  : T_LONG;
  localparam int unsigned CW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  if (BUS_WIDTH != 8 && BUS_WIDTH != 4) begin : g_bad_width
    $error("lcd_drv_gen: BUS_WIDTH must be 8 or 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_GAP,
    S_DELAY
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [9:0]           r_data;
  logic                 r_second;
  logic                 r_rs;
  logic                 r_en;
  logic                 r_ready;
  logic [BUS_WIDTH-1:0] r_lcd;

  logic                 w_accept;
  logic                 w_load_low;
  logic                 w_nib_only;
  logic                 w_long;
  logic [CW-1:0]        w_dly_last;
  logic [BUS_WIDTH-1:0] w_first;

  // Nibble-only is meaningful only on a 4-bit bus; clear/home get the long delay.
  assign w_nib_only = (BUS_WIDTH == 4) && r_data[9];
  assign w_long     = !r_data[8] && (r_data[7:2] == 6'd0) && !w_nib_only;
  assign w_dly_last = w_long ? CW'(T_LONG - 1) : CW'(T_SHORT - 1);
  assign w_first    = (BUS_WIDTH == 8) ? BUS_WIDTH'(bus.data_i[7:0])
                                       : BUS_WIDTH'(bus.data_i[7:4]);

  // Next-state decode; each state lasts until the counter reaches its length-1.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load_low  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.data_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == CW'(T_SETUP - 1)) w_state_nxt = S_STROBE;
      end
      S_STROBE: begin
        if (r_cnt == CW'(T_EN - 1)) begin
          if ((BUS_WIDTH == 4) && !w_nib_only && !r_second) w_state_nxt = S_GAP;
          else                                              w_state_nxt = S_DELAY;
        end
      end
      S_GAP: begin
        if (r_cnt == CW'(T_NIB - 1)) begin
          w_state_nxt = S_SETUP;
          w_load_low  = 1'b1;
        end
      end
      S_DELAY: begin
        if (r_cnt == w_dly_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and the shared phase counter, cleared on every state change.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + CW'(1);
    end
  end

  // Captured request, pin registers and state-decoded EN/ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data   <= '0;
      r_second <= 1'b0;
      r_rs     <= 1'b0;
      r_lcd    <= '0;
      r_en     <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_en    <= (w_state_nxt == S_STROBE);
      r_ready <= (w_state_nxt == S_IDLE);
      if (w_accept) begin
        r_data   <= bus.data_i;
        r_second <= 1'b0;
        r_rs     <= bus.data_i[8];
        r_lcd    <= w_first;
      end else if (w_load_low) begin
        r_second <= 1'b1;
        r_lcd    <= BUS_WIDTH'(r_data[3:0]);
      end
    end
  end

  assign bus.device_ready_o = r_ready;
  assign rs_o               = r_rs;
  assign rw_o               = 1'b0;
  assign en_o               = r_en;
  assign lcd_data_o         = r_lcd;

endmodule

// File: tb/tb_lcd_drv_gen.sv
// Bench for lcd_drv_gen: 8-bit and 4-bit instances against a timeline model.
module tb_lcd_drv_gen;

  localparam int TS  = 2;
  localparam int TE  = 3;
  localparam int TN  = 2;
  localparam int TSH = 10;
  localparam int TL  = 50;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  lcd_drv_gen_if if8();
  lcd_drv_gen_if if4();

  logic       rs8, rw8, en8;
  logic [7:0] lcd8;
  logic       rs4, rw4, en4;
  logic [3:0] lcd4;

  lcd_drv_gen #(.BUS_WIDTH(8), .T_SETUP(TS), .T_EN(TE), .T_NIB(TN),
                .T_SHORT(TSH), .T_LONG(TL)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .bus(if8),
    .rs_o(rs8), .rw_o(rw8), .en_o(en8), .lcd_data_o(lcd8)
  );

  lcd_drv_gen #(.BUS_WIDTH(4), .T_SETUP(TS), .T_EN(TE), .T_NIB(TN),
                .T_SHORT(TSH), .T_LONG(TL)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .bus(if4),
    .rs_o(rs4), .rw_o(rw4), .en_o(en4), .lcd_data_o(lcd4)
  );

  int n_checks;
  int n_fail;

  typedef struct {
    int         bw;
    logic [9:0] w;
    int         busy;
    int         pulses;
  } vec_t;

  vec_t vt[13];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Timeline model: sample k counts negedges after the accept edge (k=1 first).
  function automatic bit m_nib(input int bw, input logic [9:0] w);
    return (bw == 4) && w[9];
  endfunction

  function automatic bit m_full4(input int bw, input logic [9:0] w);
    return (bw == 4) && !w[9];
  endfunction

  function automatic int m_busy(input int bw, input logic [9:0] w);
    int dly;
    dly = (!w[8] && (w[7:2] == 6'd0) && !m_nib(bw, w)) ? TL : TSH;
    return m_full4(bw, w) ? 2 * (TS + TE) + TN + dly : TS + TE + dly;
  endfunction

  function automatic logic m_en(input int bw, input logic [9:0] w, input int k);
    if (k > TS && k <= TS + TE) return 1'b1;
    if (m_full4(bw, w) && k > 2 * TS + TE + TN && k <= 2 * (TS + TE) + TN) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_data(input int bw, input logic [9:0] w, input int k);
    if (bw == 8) return int'(w[7:0]);
    if (m_full4(bw, w) && k > TS + TE + TN) return int'(w[3:0]);
    return int'(w[7:4]);
  endfunction

  task automatic drive(input int bw, input logic v, input logic [9:0] d);
    if (bw == 8) begin
      if8.data_valid_i = v;
      if8.data_i       = d;
    end else begin
      if4.data_valid_i = v;
      if4.data_i       = d;
    end
  endtask

  task automatic get(input int bw, output logic rdy, output logic en,
                     output logic rs, output logic rw, output int dat);
    if (bw == 8) begin
      rdy = if8.device_ready_o; en = en8; rs = rs8; rw = rw8; dat = int'(lcd8);
    end else begin
      rdy = if4.device_ready_o; en = en4; rs = rs4; rw = rw4; dat = int'(lcd4);
    end
  endtask

  // One transaction; returns measured busy length, EN pulse count, trace errors.
  task automatic run_txn(input int bw, input logic [9:0] w,
                         output int busy, output int pulses, output int err);
    logic rdy, en, rs, rw, prev_en;
    int   dat;
    bit   done;
    busy = 0; pulses = 0; err = 0; prev_en = 1'b0; done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      get(bw, rdy, en, rs, rw, dat);
      if (rdy === 1'b1) break;
      @(negedge clk);
    end
    drive(bw, 1'b1, w);
    @(negedge clk);
    drive(bw, 1'b0, 10'($urandom));
    for (int k = 1; k <= 400; k++) begin
      get(bw, rdy, en, rs, rw, dat);
      if (en !== m_en(bw, w, k))           err++;
      if (dat != m_data(bw, w, k))         err++;
      if (rs !== w[8])                     err++;
      if (rw !== 1'b0)                     err++;
      if (rdy !== (k > m_busy(bw, w)))     err++;
      if (en === 1'b1 && prev_en !== 1'b1) pulses++;
      prev_en = en;
      if (rdy === 1'b1) begin
        done = 1'b1;
        break;
      end
      busy++;
      @(negedge clk);
    end
    if (!done) err++;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   busy, pulses, err, en_cnt, rdy_bad, idx, cur_low, cur_high;
    logic rdy, en, rs, rw, prev_en, rw_bad;
    int   dat;
    bit   seen;
    int   low_runs[$];
    int   high_runs[$];
    int   en_words[$];
    logic [9:0] q[3];
    int   exp_low[3];

    n_checks = 0;
    n_fail   = 0;

    vt[0]  = '{8, 10'h141, 15, 1};
    vt[1]  = '{8, 10'h001, 55, 1};
    vt[2]  = '{8, 10'h004, 15, 1};
    vt[3]  = '{8, 10'h002, 55, 1};
    vt[4]  = '{8, 10'h003, 55, 1};
    vt[5]  = '{8, 10'h101, 15, 1};
    vt[6]  = '{8, 10'h201, 55, 1};
    vt[7]  = '{4, 10'h128, 22, 2};
    vt[8]  = '{4, 10'h230, 15, 1};
    vt[9]  = '{4, 10'h030, 22, 2};
    vt[10] = '{4, 10'h001, 62, 2};
    vt[11] = '{4, 10'h201, 15, 1};
    vt[12] = '{4, 10'h202, 15, 1};

    rst = 1'b1;
    drive(8, 1'b0, 10'h0);
    drive(4, 1'b0, 10'h0);
    repeat (3) @(negedge clk);

    // Reset state of both instances
    check("rst_ready8", int'(if8.device_ready_o), 1);
    check("rst_en8",    int'(en8), 0);
    check("rst_rs8",    int'(rs8), 0);
    check("rst_lcd8",   int'(lcd8), 0);
    check("rst_ready4", int'(if4.device_ready_o), 1);
    check("rst_lcd4",   int'(lcd4), 0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a strobe
    drive(8, 1'b1, 10'h141);
    drive(4, 1'b1, 10'h128);
    @(negedge clk);
    drive(8, 1'b0, 10'h0);
    drive(4, 1'b0, 10'h0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (en8 === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("mid_strobe_reached", int'(seen), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_en8",    int'(en8), 0);
    check("mid_rst_rs8",    int'(rs8), 0);
    check("mid_rst_lcd8",   int'(lcd8), 0);
    check("mid_rst_ready8", int'(if8.device_ready_o), 1);
    check("mid_rst_en4",    int'(en4), 0);
    check("mid_rst_lcd4",   int'(lcd4), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    en_cnt = 0;
    rdy_bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (en8 !== 1'b0 || en4 !== 1'b0) en_cnt++;
      if (if8.device_ready_o !== 1'b1) rdy_bad++;
    end
    check("post_rst_en_pulses", en_cnt, 0);
    check("post_rst_not_ready", rdy_bad, 0);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      run_txn(vt[i].bw, vt[i].w, busy, pulses, err);
      check($sformatf("vec%0d_busy", i),   busy,   vt[i].busy);
      check($sformatf("vec%0d_pulses", i), pulses, vt[i].pulses);
      check($sformatf("vec%0d_trace", i),  err,    0);
    end

    // Back-to-back with valid held high and garbage data while busy
    q[0] = 10'h141; q[1] = 10'h001; q[2] = 10'h143;
    exp_low[0] = 15; exp_low[1] = 55; exp_low[2] = 15;
    idx = 0; cur_low = 0; cur_high = 0; prev_en = 1'b0; rw_bad = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      get(8, rdy, en, rs, rw, dat);
      if (rw !== 1'b0) rw_bad = 1'b1;
      if (en === 1'b1 && prev_en !== 1'b1) en_words.push_back(dat + (rs ? 256 : 0));
      prev_en = en;
      if (rdy === 1'b1) begin
        if (cur_low > 0) begin
          low_runs.push_back(cur_low);
          cur_low = 0;
        end
        cur_high++;
        if (idx < 3) begin
          drive(8, 1'b1, q[idx]);
          idx++;
          if (idx > 1) high_runs.push_back(cur_high);
          cur_high = 0;
        end else begin
          drive(8, 1'b0, 10'h0);
          break;
        end
      end else begin
        cur_low++;
        drive(8, 1'b1, 10'($urandom));
      end
      @(negedge clk);
    end
    drive(8, 1'b0, 10'h0);
    check("b2b_busy_count", low_runs.size(), 3);
    check("b2b_idle_count", high_runs.size(), 2);
    check("b2b_en_count",   en_words.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2b_busy%0d", i), (i < low_runs.size()) ? low_runs[i] : -1, exp_low[i]);
      check($sformatf("b2b_word%0d", i), (i < en_words.size()) ? en_words[i] : -1, int'(q[i]));
    end
    for (int i = 0; i < 2; i++)
      check($sformatf("b2b_idle%0d", i), (i < high_runs.size()) ? high_runs[i] : -1, 1);
    check("b2b_rw_low", int'(rw_bad), 0);
    @(negedge clk);

    // Randomised transactions against the model
    for (int i = 0; i < 30; i++) begin
      int         bw;
      logic [9:0] w;
      bw = ($urandom_range(0, 1) == 1) ? 8 : 4;
      w  = 10'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        w[8]   = 1'b0;
        w[7:2] = 6'd0;
      end
      run_txn(bw, w, busy, pulses, err);
      check($sformatf("rnd%0d_busy", i),   busy,   m_busy(bw, w));
      check($sformatf("rnd%0d_pulses", i), pulses, m_full4(bw, w) ? 2 : 1);
      check($sformatf("rnd%0d_trace", i),  err,    0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_drv_gen.md
Name: lcd_drv_gen

Overview:
Parametrised next-generation HD44780-class character-LCD driver. It accepts one command or data byte per transaction over a Ready/Valid interface and drives RS/EN/DB with programmable setup, strobe and post-command delays. It supports both 8-bit and 4-bit bus modes; in 4-bit mode it can also send a single high nibble, which the 4-bit init sequence needs. It sits between the text/command sequencer and the LCD pins.

Parameters:
BUS_WIDTH, 8, LCD data bus width; legal values 8 or 4.
T_SETUP, 5, cycles RS/DB are stable before EN rises (≥1).
T_EN, 50, cycles EN is held high (≥1).
T_NIB, 100, cycles EN is low between high and low nibble in 4-bit mode (≥1).
T_SHORT, 4000, post-strobe busy delay in cycles for normal commands and data (≥1).
T_LONG, 164000, post-strobe busy delay in cycles for clear/home commands (≥1).

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
data_i  in  10  [7:0] byte; [8] RS (1=data, 0=instruction); [9] nibble-only flag (4-bit mode only; ignored when BUS_WIDTH=8)
data_valid_i  in  1  data_i is valid
device_ready_o  out  1  driver can accept a transaction
rs_o  out  1  LCD register select
rw_o  out  1  LCD read/write; always 0
en_o  out  1  LCD enable strobe
lcd_data_o  out  BUS_WIDTH  LCD data bus

Behaviour:
- Reset (rst_i=1 at clk_i edge): state IDLE; rs_o=0, en_o=0, lcd_data_o=0, counter=0, device_ready_o=1 on the next cycle. Reset mid-transaction aborts immediately. EN never stays high past the reset edge.
- States: IDLE, SETUP, STROBE, GAP, DELAY. en_o=1 only in STROBE. device_ready_o=1 only in IDLE. Both are decoded from registered state and are glitch-free.
- Accept: on the edge where data_valid_i && device_ready_o, capture data_i into an internal 10-bit register. Load rs_o and lcd_data_o (8-bit: byte; 4-bit: byte[7:4]) and enter SETUP. Valid without ready is ignored, and data_i is not sampled.
- A state with length N lasts exactly N clock cycles. One counter clears on every state change and is sized by $clog2 of the largest parameter.
- SETUP (T_SETUP) → STROBE (T_EN).
- After STROBE:
  - 8-bit mode, nibble-only, or second nibble already sent → DELAY.
  - 4-bit mode with first nibble done → GAP (T_NIB, EN low, bus held). On the GAP→SETUP transition, lcd_data_o loads byte[3:0]; then SETUP → STROBE again.
- DELAY length:
  - T_LONG when RS=0, byte[7:2]==0 and not nibble-only (clear 0x01, home 0x02/0x03).
  - T_SHORT otherwise.
- DELAY → IDLE.
- Busy time, from the accept edge to device_ready_o high again:
  - 8-bit or nibble-only: T_SETUP+T_EN+T_DLY cycles.
  - 4-bit full byte: 2·(T_SETUP+T_EN)+T_NIB+T_DLY cycles.
- rs_o and lcd_data_o hold their last values in IDLE and change only on accept or the nibble switch.
- Back-to-back: valid held high continuously → the next accept occurs on the first IDLE cycle, so IDLE lasts exactly 1 cycle.
- Illegal BUS_WIDTH: elaboration error.

Test Plan:
(All with T_SETUP=2, T_EN=3, T_NIB=2, T_SHORT=10, T_LONG=50.)
1. Reset held 3 cycles mid-STROBE → en_o=0, rs_o=0, lcd_data_o=0 the next cycle, device_ready_o=1, no further EN pulses.
2. BUS_WIDTH=8, send 0x141 (RS=1, 'A') → lcd_data_o=0x41, rs_o=1; en_o high exactly 3 cycles starting 2 cycles after accept; ready low for 15 cycles.
3. BUS_WIDTH=8, send 0x001 (clear) → DELAY 50 cycles; ready low for 55 cycles. Send 0x004 → DELAY 10 cycles.
4. BUS_WIDTH=4, send 0x128 → lcd_data_o=0x2 for first EN pulse, 0x8 for second; the EN pulses are separated by 2+2 low cycles; ready low for 22 cycles; exactly 2 EN pulses.
5. BUS_WIDTH=4, send 0x230 (nibble-only, 0x3) → one EN pulse with lcd_data_o=0x3, rs_o=0; ready low for 15 cycles; a byte of 0x30 would not trigger T_LONG.
6. Valid held high with 3 queued words → each accepted on the single IDLE cycle; data_i changes while busy are ignored; rw_o=0 throughout.
